fifo_prog: RTL and testbench
============================

# fifo_prog

Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds, selectable standard or first-word-fall-through read mode, full-and-read pass-through, synchronous flush, and sticky overflow/underflow error flags. It is the general-purpose single-clock buffer for datapath blocks that need early back-pressure warnings and a visible occupancy count.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 16, number of entries (≥2; need not be a power of two)
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of contents and error flags
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_THRESH
- rd_en  in  1  read request (FWFT: acknowledge of head word)
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data holds a valid word (see Operation)
- empty  out  1  count == 0
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Read accepted (do_rd) = rd_en && !empty.
- Write accepted (do_wr) = wr_en && (!full || do_rd); a full FIFO accepts a write in the same cycle as an accepted read.
- count: +1 on write only, −1 on read only, unchanged on both or neither.
- Pointers advance by 1 on accept and wrap from DEPTH-1 to 0 by explicit compare; never rely on natural overflow.
- Standard mode (FWFT=0): on do_rd, rd_data ← mem[rd_ptr] and rd_valid pulses high for exactly the next cycle. rd_data holds its value until the next accepted read.
- FWFT mode (FWFT=1): rd_data presents mem[rd_ptr] whenever !empty. rd_valid = !empty. rd_en consumes the head word. rd_data is don't-care while rd_valid=0.
- Empty FIFO with wr_en and rd_en both high: the write is accepted and the read is rejected, setting underflow.
- overflow is set when wr_en && !do_wr. underflow is set when rd_en && empty. Both flags hold until flush or reset.
- flush: pointers, count, overflow, underflow and rd_valid go to 0. Standard mode also sets rd_data to 0. Any wr_en/rd_en in the flush cycle is ignored and flags nothing. Memory contents are not cleared.
- Reset (rst_n=0 at an edge): same effect as flush, and it takes priority over flush. Applying reset mid-stream discards all contents.

## Timing
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
- full, empty, almost_* are combinational decodes of registered count. They update in the cycle after the accepting edge.
- Write-to-read latency: in FWFT mode, a word written at edge N is visible on rd_data after edge N. In standard mode, a read requested in the cycle after edge N returns data after the following edge.
- Standard-mode read latency is 1 cycle from an accepted rd_en to rd_valid/rd_data.
- No combinational path from wr_en/rd_en to any output, except FWFT rd_data indexing by registered rd_ptr.

## Structure
- Package fifo_pkg holds the width helper functions (addr_w(DEPTH), cnt_w(DEPTH)) and the read-mode localparams (FIFO_STD=0, FIFO_FWFT=1).
- Sub-module fifo_ram: DEPTH×DATA_WIDTH storage with one synchronous write port and one asynchronous read address. fifo_prog owns pointers, count, flags and the output register.
- fifo_prog elaborates with an error if AF_THRESH or AE_THRESH is out of range.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2.
- Fill/drain: write 0x00..0x0F, then 16 reads → full=1 after the 16th write; reads return 0x00..0x0F in order; empty=1 at end; no error flags.
- Thresholds: write 14 words → almost_full rises the cycle after the 14th write, almost_empty falls after the 3rd. Reading back to 2 words reasserts almost_empty.
- Full pass-through: at count=16, wr_en and rd_en high with wr_data=0xA5 → count stays 16, overflow stays 0, and 0xA5 is read out 16 reads later.
- Errors: write while full without read → overflow=1 and count stays 16. Read while empty → underflow=1. Both flags hold until flush, which clears everything to reset values.
- FWFT=1: a single write of 0x3C → rd_valid=1 and rd_data=0x3C the next cycle with no rd_en. After rd_en, rd_valid=0.
- Reset mid-operation: drop rst_n at count=7 → next cycle all outputs equal reset values. A subsequent write/read of 0x11 returns 0x11.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers and read-mode constants for the programmable FIFO.
package fifo_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  // Pointer width; at least one bit so a 1-entry address is still legal.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width; must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; occupancy is tracked by the controller.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_prog.sv
// Single-clock FIFO with programmable thresholds, standard/FWFT read modes,
// full-and-read pass-through, synchronous flush and sticky error flags.
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FWFT       = FIFO_STD,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      full,
  output logic                      almost_full,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      empty,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned AW = addr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  // Elaboration-time parameter sanity checks.
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("fifo_prog: DATA_WIDTH must be at least 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_prog: DEPTH must be at least 2");
  end
  if (FWFT > FIFO_FWFT) begin : g_bad_mode
    $error("fifo_prog: FWFT must be 0 or 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_prog: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_prog: AE_THRESH must be in 0..DEPTH-1");
  end

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  empty_w, full_w;
  logic                  do_rd, do_wr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Status decodes come only from registered count.
  always_comb begin
    empty_w = (count_q == '0);
    full_w  = (count_q == CW'(DEPTH));
    // Requests in a flush cycle are ignored entirely.
    do_rd   = rd_en && !empty_w && !flush;
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    do_wr   = wr_en && (!full_w || do_rd) && !flush;
  end

  // Next-state for pointers, occupancy, error flags and the standard-mode output register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      rd_data_d   = '0;
    end else begin
      if (do_wr) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (do_rd) begin
        rd_ptr_d   = ptr_inc(rd_ptr_q);
        rd_valid_d = 1'b1;
        rd_data_d  = ram_rdata;
      end

      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      if (wr_en && !do_wr) begin
        overflow_d = 1'b1;
      end
      // Includes the empty write+read case: the write lands, the read is rejected.
      if (rd_en && empty_w) begin
        underflow_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset taking priority over flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (do_wr && rst_n),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign count        = count_q;
  assign empty        = empty_w;
  assign full         = full_w;
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // FWFT exposes the head word directly; standard mode uses the output register.
  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign rd_data  = ram_rdata;
    assign rd_valid = !empty_w;
  end else begin : g_std
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_prog.sv
// Bench: a standard-mode and an FWFT-mode FIFO share one stimulus stream and
// are checked every cycle against a queue-based model, plus literal checks.
module tb_fifo_prog;

  logic       clk = 1'b0;
  logic       rst_n, flush, wr_en, rd_en;
  logic [7:0] wr_data;

  logic       s_full, s_af, s_empty, s_ae, s_rd_valid, s_ovf, s_unf;
  logic [7:0] s_rd_data;
  logic [4:0] s_count;
  logic       f_full, f_af, f_empty, f_ae, f_rd_valid, f_ovf, f_unf;
  logic [7:0] f_rd_data;
  logic [4:0] f_count;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  fifo_prog #(
    .DATA_WIDTH (8), .DEPTH (16), .FWFT (0), .AF_THRESH (14), .AE_THRESH (2)
  ) u_std (
    .clk (clk), .rst_n (rst_n), .flush (flush), .wr_en (wr_en), .wr_data (wr_data),
    .full (s_full), .almost_full (s_af), .rd_en (rd_en), .rd_data (s_rd_data),
    .rd_valid (s_rd_valid), .empty (s_empty), .almost_empty (s_ae), .count (s_count),
    .overflow (s_ovf), .underflow (s_unf)
  );

  fifo_prog #(
    .DATA_WIDTH (8), .DEPTH (16), .FWFT (1), .AF_THRESH (14), .AE_THRESH (2)
  ) u_fwft (
    .clk (clk), .rst_n (rst_n), .flush (flush), .wr_en (wr_en), .wr_data (wr_data),
    .full (f_full), .almost_full (f_af), .rd_en (rd_en), .rd_data (f_rd_data),
    .rd_valid (f_rd_valid), .empty (f_empty), .almost_empty (f_ae), .count (f_count),
    .overflow (f_ovf), .underflow (f_unf)
  );

  // Reference model: contents as a queue, flags and standard-mode output as plain bits.
  bit [7:0] mq[$];
  bit       m_ovf, m_unf, m_rd_valid;
  bit [7:0] m_rd_data;

  always @(posedge clk) begin : model
    bit r_ok, w_ok, was_empty;
    if (!rst_n || flush) begin
      mq.delete();
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
      m_rd_valid = 1'b0;
      m_rd_data  = 8'h00;
    end else begin
      was_empty  = (mq.size() == 0);
      r_ok       = rd_en && !was_empty;
      w_ok       = wr_en && (mq.size() < 16 || r_ok);
      m_rd_valid = r_ok;
      if (r_ok) m_rd_data = mq.pop_front();
      if (w_ok) mq.push_back(wr_data);
      if (wr_en && !w_ok) m_ovf = 1'b1;
      if (rd_en && was_empty) m_unf = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      int n;
      n = mq.size();
      chk("s_count", 32'(s_count), 32'(n));
      chk("s_empty", 32'(s_empty), 32'(n == 0));
      chk("s_full", 32'(s_full), 32'(n == 16));
      chk("s_af", 32'(s_af), 32'(n >= 14));
      chk("s_ae", 32'(s_ae), 32'(n <= 2));
      chk("s_ovf", 32'(s_ovf), 32'(m_ovf));
      chk("s_unf", 32'(s_unf), 32'(m_unf));
      chk("s_rd_valid", 32'(s_rd_valid), 32'(m_rd_valid));
      chk("s_rd_data", 32'(s_rd_data), 32'(m_rd_data));
      chk("f_count", 32'(f_count), 32'(n));
      chk("f_flags", {27'd0, f_full, f_af, f_empty, f_ae, f_ovf},
          {27'd0, n == 16, n >= 14, n == 0, n <= 2, m_ovf});
      chk("f_unf", 32'(f_unf), 32'(m_unf));
      chk("f_rd_valid", 32'(f_rd_valid), 32'(n != 0));
      if (n != 0) chk("f_rd_data", 32'(f_rd_data), 32'(mq[0]));
    end
  end

  task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit f, input bit rs);
    wr_en = w; wr_data = d; rd_en = r; flush = f; rst_n = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int pw, pr;
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    check_en = 1'b1;

    // Reset values.
    chk("rst_count", 32'(s_count), 0);
    chk("rst_status", {28'd0, s_empty, s_full, s_ae, s_af}, 32'b1010);
    chk("rst_rd", {23'd0, s_rd_valid, s_rd_data}, 0);
    chk("rst_err", {30'd0, s_ovf, s_unf}, 0);

    // Fill 0x00..0x0F.
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 1);
    chk("fill_count", 32'(s_count), 16);
    chk("fill_full", {30'd0, s_full, s_af}, 32'b11);

    // Full pass-through.
    cyc(1, 8'hA5, 1, 0, 1);
    chk("pt_count", 32'(s_count), 16);
    chk("pt_ovf", 32'(s_ovf), 0);
    chk("pt_rd", {23'd0, s_rd_valid, s_rd_data}, 32'h100);
    chk("pt_fwft_head", 32'(f_rd_data), 32'h01);

    // Overflow.
    cyc(1, 8'hEE, 0, 0, 1);
    chk("ovf_flag", 32'(s_ovf), 1);
    chk("ovf_count", 32'(s_count), 16);

    // Drain: 0x01..0x0F then 0xA5.
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0, 1);
    chk("drain_last", 32'(s_rd_data), 32'hA5);
    chk("drain_empty", 32'(s_empty), 1);

    // Underflow; overflow must still hold.
    cyc(0, 8'h00, 1, 0, 1);
    chk("unf_flags", {30'd0, s_ovf, s_unf}, 32'b11);

    // Flush clears flags and output register.
    cyc(1, 8'h77, 1, 1, 1);
    chk("flush_err", {30'd0, s_ovf, s_unf}, 0);
    chk("flush_rd", {23'd0, s_rd_valid, s_rd_data}, 0);
    chk("flush_count", 32'(s_count), 0);

    // Thresholds.
    for (int i = 1; i <= 14; i++) begin
      cyc(1, 8'(8'h40 + i), 0, 0, 1);
      if (i == 2) chk("ae_at2", 32'(s_ae), 1);
      if (i == 3) chk("ae_at3", 32'(s_ae), 0);
      if (i == 13) chk("af_at13", 32'(s_af), 0);
      if (i == 14) chk("af_at14", 32'(s_af), 1);
    end
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 8'h00, 1, 0, 1);
      if (i == 11) chk("ae_at3_down", 32'(s_ae), 0);
    end
    chk("ae_at2_down", {27'd0, s_count, 1'b0} | 32'(s_ae), 32'h5);

    // FWFT single word.
    cyc(0, 8'h00, 0, 1, 1);
    cyc(1, 8'h3C, 0, 0, 1);
    chk("fwft_vis", {23'd0, f_rd_valid, f_rd_data}, 32'h13C);
    chk("std_novalid", 32'(s_rd_valid), 0);
    cyc(0, 8'h00, 1, 0, 1);
    chk("fwft_gone", 32'(f_rd_valid), 0);
    chk("std_3c", {23'd0, s_rd_valid, s_rd_data}, 32'h13C);

    // Reset mid-operation at count 7.
    for (int i = 0; i < 7; i++) cyc(1, 8'(8'h60 + i), 0, 0, 1);
    chk("mid_count", 32'(s_count), 7);
    cyc(1, 8'h99, 1, 1, 0);
    chk("mid_rst_count", 32'(f_count), 0);
    chk("mid_rst_status", {28'd0, s_empty, s_full, s_ae, s_af}, 32'b1010);
    chk("mid_rst_rd", {23'd0, s_rd_valid, s_rd_data}, 0);
    cyc(1, 8'h11, 0, 0, 1);
    chk("post_rst_fwft", 32'(f_rd_data), 32'h11);
    cyc(0, 8'h00, 1, 0, 1);
    chk("post_rst_std", {23'd0, s_rd_valid, s_rd_data}, 32'h111);

    // Randomized traffic in phases biased toward filling, draining or balance.
    pw = 50; pr = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(0, 2))
          0:       begin pw = 85; pr = 20; end
          1:       begin pw = 20; pr = 85; end
          default: begin pw = 60; pr = 60; end
        endcase
      end
      cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
          $urandom_range(0, 249) == 0, $urandom_range(0, 599) != 0);
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
